// File: rtl/port_timer_pkg.sv
// port_timer_pkg: shared definitions for the port_timer block.
//   - register offsets inside the 8-entry window
//   - CTRL / STATUS bit positions
//   - register-select enum and the offset decoder
package port_timer_pkg;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_RELOAD  = 3'd1;
    localparam logic [2:0] OFF_COUNT   = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_CAPTURE = 3'd4;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_IE_BIT   = 2;
    localparam int CTRL_PSEL_LSB = 4;

    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_CAPF_BIT = 1;

    typedef enum logic [2:0] {
        SEL_CTRL    = 3'd0,
        SEL_RELOAD  = 3'd1,
        SEL_COUNT   = 3'd2,
        SEL_STATUS  = 3'd3,
        SEL_CAPTURE = 3'd4,
        SEL_RSVD    = 3'd5
    } reg_sel_e;

    // Map a window offset onto the register it selects.
    function automatic reg_sel_e decode_offset(input logic [2:0] off);
        reg_sel_e sel;
        case (off)
            OFF_CTRL:    sel = SEL_CTRL;
            OFF_RELOAD:  sel = SEL_RELOAD;
            OFF_COUNT:   sel = SEL_COUNT;
            OFF_STATUS:  sel = SEL_STATUS;
            OFF_CAPTURE: sel = SEL_CAPTURE;
            default:     sel = SEL_RSVD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/port_timer_presc.sv
// port_timer_presc: prescaler producing one tick every 2^psel clocks.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   en    : count enable (counter frozen while low)
//   clr   : synchronous clear of the prescaler counter
//   psel  : log2 of the tick period, saturated at PRESC_W
//   tick  : high for one clock at the end of each period
module port_timer_presc
    import port_timer_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] psel,
    output logic       tick
);

    localparam logic [31:0] PSEL_MAX = PRESC_W;

    logic [PRESC_W-1:0] cnt_r;
    logic [PRESC_W-1:0] mask_s;
    logic [31:0]        psel_eff_s;

    // Saturate psel and build the low-bit mask that defines the period.
    always_comb begin
        psel_eff_s = ({28'd0, psel} > PSEL_MAX) ? PSEL_MAX : {28'd0, psel};
        mask_s     = ~({PRESC_W{1'b1}} << psel_eff_s);
    end

    // The tick fires when all masked bits are set, i.e. after 2^psel clocks.
    assign tick = en & ((cnt_r & mask_s) == mask_s);

    // Free-running prescaler counter; clr restarts the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/port_timer.sv
// port_timer: memory-mapped down-counting timer with prescaler and interrupt.
//   Register window BASE_ADDR..BASE_ADDR+7:
//     0 CTRL (EN, AUTO, IE, PSEL[7:4])  1 RELOAD  2 COUNT
//     3 STATUS (PEND bit0, CAPF bit1)   4 CAPTURE  5-7 reserved
//   Ports: clk, reset (async active-low), data_address, read_strobe,
//          write_strobe, data_out (CPU write data), rd_data (combinational
//          read data), sel (address in window), intr (interrupt request),
//          cap_in (only with PORT_TIMER_CAPTURE_EN).
//   Optional feature macro: PORT_TIMER_CAPTURE_EN adds the input-capture unit.
module port_timer
    import port_timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hF0,
    parameter int         PRESC_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_address,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] data_out,
`ifdef PORT_TIMER_CAPTURE_EN
    input  logic       cap_in,
`endif
    output logic [7:0] rd_data,
    output logic       sel,
    output logic       intr
);

    logic       en_r, auto_r, ie_r;
    logic [3:0] psel_r;
    logic [7:0] reload_r, count_r;
    logic       pend_r;

    logic [7:0] offset_s;
    logic       sel_s;
    reg_sel_e   reg_sel_s;
    logic       wr_s, wr_ctrl_s, wr_reload_s, wr_count_s, wr_status_s;
    logic       presc_clr_s, tick_s, expire_s;
    logic [7:0] capture_s;
    logic       capf_s;

    // Reads never have side effects, so the read qualifier is not needed.
    logic       unused_s;
    assign unused_s = read_strobe;

    // Offset subtraction lets BASE_ADDR sit on any byte boundary.
    assign offset_s  = data_address - BASE_ADDR;
    assign sel_s     = (offset_s[7:3] == 5'd0);
    assign reg_sel_s = decode_offset(offset_s[2:0]);
    assign sel       = sel_s;

    assign wr_s        = write_strobe & sel_s;
    assign wr_ctrl_s   = wr_s & (reg_sel_s == SEL_CTRL);
    assign wr_reload_s = wr_s & (reg_sel_s == SEL_RELOAD);
    assign wr_count_s  = wr_s & (reg_sel_s == SEL_COUNT);
    assign wr_status_s = wr_s & (reg_sel_s == SEL_STATUS);

    // Only a 0->1 transition of EN restarts the prescaler phase.
    assign presc_clr_s = wr_ctrl_s & data_out[CTRL_EN_BIT] & ~en_r;

    // A COUNT write swallows a coincident tick, including its expiry.
    assign expire_s = tick_s & ~wr_count_s & (count_r == 8'd0);

    port_timer_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (en_r),
        .clr   (presc_clr_s),
        .psel  (psel_r),
        .tick  (tick_s)
    );

    // Control, reload, count and pending-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r     <= 1'b0;
            auto_r   <= 1'b0;
            ie_r     <= 1'b0;
            psel_r   <= 4'd0;
            reload_r <= 8'd0;
            count_r  <= 8'd0;
            pend_r   <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                en_r   <= data_out[CTRL_EN_BIT];
                auto_r <= data_out[CTRL_AUTO_BIT];
                ie_r   <= data_out[CTRL_IE_BIT];
                psel_r <= data_out[CTRL_PSEL_LSB +: 4];
            end else if (expire_s && !auto_r) begin
                en_r   <= 1'b0;
            end

            if (wr_reload_s) begin
                reload_r <= data_out;
            end

            if (wr_count_s) begin
                count_r <= data_out;
            end else if (tick_s) begin
                if (count_r != 8'd0) begin
                    count_r <= count_r - 8'd1;
                end else if (auto_r) begin
                    count_r <= reload_r;
                end
            end

            // Expiry has priority over a software clear in the same cycle.
            if (expire_s) begin
                pend_r <= 1'b1;
            end else if (wr_status_s && data_out[STAT_PEND_BIT]) begin
                pend_r <= 1'b0;
            end
        end
    end

`ifdef PORT_TIMER_CAPTURE_EN
    logic [1:0] cap_sync_r;
    logic       cap_prev_r;
    logic [7:0] capture_r;
    logic       capf_r;
    logic       cap_rise_s;

    assign cap_rise_s = cap_sync_r[1] & ~cap_prev_r;

    // Two-flop synchroniser, edge detector, capture register and CAPF flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_sync_r <= 2'b00;
            cap_prev_r <= 1'b0;
            capture_r  <= 8'd0;
            capf_r     <= 1'b0;
        end else begin
            cap_sync_r <= {cap_sync_r[0], cap_in};
            cap_prev_r <= cap_sync_r[1];
            if (cap_rise_s) begin
                capture_r <= count_r;
                capf_r    <= 1'b1;
            end else if (wr_status_s && data_out[STAT_CAPF_BIT]) begin
                capf_r    <= 1'b0;
            end
        end
    end

    assign capture_s = capture_r;
    assign capf_s    = capf_r;
`else
    assign capture_s = 8'd0;
    assign capf_s    = 1'b0;
`endif

    // Without the capture unit capf_s is tied low, leaving intr = IE & PEND.
    assign intr = ie_r & (pend_r | capf_s);

    // Combinational read mux; anything outside the window reads zero.
    always_comb begin
        rd_data = 8'd0;
        if (sel_s) begin
            case (reg_sel_s)
                SEL_CTRL:    rd_data = {psel_r, 1'b0, ie_r, auto_r, en_r};
                SEL_RELOAD:  rd_data = reload_r;
                SEL_COUNT:   rd_data = count_r;
                SEL_STATUS:  rd_data = {6'd0, capf_s, pend_r};
                SEL_CAPTURE: rd_data = capture_s;
                default:     rd_data = 8'd0;
            endcase
        end else begin
            rd_data = 8'd0;
        end
    end

endmodule

// File: doc/port_timer.md
PORT_TIMER -- requirements
Module: port_timer

Interface
REQ-001 Parameter BASE_ADDR, default 8'hF0, SHALL set the data-bus base address of the 8-entry register window (BASE_ADDR..BASE_ADDR+7).
REQ-002 Parameter PRESC_W, default 8, SHALL set the prescaler counter width.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_address  input  8  CPU data address.
REQ-006 read_strobe  input  1  CPU read qualifier.
REQ-007 write_strobe  input  1  CPU write qualifier; a write takes effect at the rising edge where it is high.
REQ-008 data_out  input  8  CPU write data.
REQ-009 rd_data  output  8  register read data; combinational.
REQ-010 sel  output  1  high when data_address lies in the window; the system uses it to mux rd_data onto the CPU data_in.
REQ-011 intr  output  1  interrupt request to the CPU.

Function
REQ-012 Register map, by offset: 0 CTRL, 1 RELOAD, 2 COUNT, 3 STATUS, 4 CAPTURE (REQ-030), 5-7 reserved.
REQ-013 CTRL SHALL be bit0 EN, bit1 AUTO, bit2 IE, bits7:4 PSEL; bit3 reads 0.
REQ-014 Reserved offsets SHALL read 8'h00 and ignore writes.
REQ-015 rd_data SHALL be the addressed register when sel=1, else 8'h00; reads SHALL have no side effects.
REQ-016 With EN=1, the prescaler SHALL emit one tick every 2^PSEL clocks; PSEL=0 means a tick every clock.
REQ-017 PSEL values above PRESC_W SHALL saturate at PRESC_W.
REQ-018 A 0->1 write of EN SHALL clear the prescaler, so the first tick occurs 2^PSEL clocks later.
REQ-019 On a tick with COUNT>0, COUNT SHALL decrement by 1.
REQ-020 On a tick with COUNT==0, STATUS.PEND (bit0) SHALL set.
REQ-021 In the REQ-020 case, COUNT SHALL load RELOAD if AUTO=1; otherwise EN SHALL clear and COUNT SHALL stay 0.
REQ-022 Writing COUNT SHALL load it directly; a same-cycle tick is discarded and the write wins.
REQ-023 Writing STATUS with bit0=1 SHALL clear PEND; if an expiry occurs the same cycle, the set wins.
REQ-024 intr SHALL equal PEND AND IE.
REQ-025 intr SHALL stay asserted until PEND is cleared by software.
REQ-026 With RELOAD=0 and AUTO=1, expiry SHALL repeat on every tick.
REQ-027 A write with EN=0 SHALL freeze the counter and prescaler; COUNT, PEND and RELOAD are retained.

Reset
REQ-028 While reset is low: CTRL, RELOAD, COUNT, STATUS, CAPTURE and the prescaler SHALL be 0, and intr SHALL be 0. rd_data and sel follow the address combinationally.
REQ-029 Reset asserted mid-count SHALL abort immediately. After release, the block SHALL stay idle until EN is written.

Configuration
REQ-030 With macro PORT_TIMER_CAPTURE_EN defined:
- input cap_in (1 bit) SHALL be added, synchronised through two flops.
- a synchronised rising edge SHALL latch COUNT into CAPTURE (offset 4) and set STATUS bit1 CAPF.
- writing STATUS with bit1=1 SHALL clear CAPF; set wins on collision.
- intr SHALL be IE AND (PEND OR CAPF).
REQ-031 Without PORT_TIMER_CAPTURE_EN: cap_in is absent, offset 4 and STATUS bit1 SHALL read 0, and intr follows REQ-024.

Structure
REQ-032 A shared package port_timer_pkg SHALL hold the register offsets, the CTRL/STATUS bit positions and the register-select enum.
REQ-033 The prescaler SHALL be the sub-module port_timer_presc (inputs clk, reset, en, clr, psel; output tick).

Verification
REQ-034 Reset release -> all registers read 0; intr=0; sel=1 exactly for addresses F0-F7.
REQ-035 RELOAD=3, COUNT=3, CTRL=8'h07 (PSEL=0):
- COUNT reads 2,1,0 over the next 3 clocks.
- PEND and intr rise on the 4th tick; COUNT reads 3.
- expiries then repeat every 4 clocks.
REQ-036 COUNT=2, CTRL=8'h21 (one-shot, PSEL=2):
- PEND sets 12 clocks after the CTRL write.
- EN reads 0 afterwards; COUNT stays 0.
REQ-037 Write STATUS=8'h01 in the same cycle as an expiry -> PEND remains 1. A write in the next cycle clears it and drops intr.
REQ-038 COUNT write of 8'h55 coinciding with a tick -> COUNT reads 8'h55, not 8'h54.
REQ-039 With PORT_TIMER_CAPTURE_EN and COUNT=8'h40:
- a cap_in rising edge -> CAPTURE reads the COUNT value 3 clocks later, CAPF=1 and intr=1 (IE=1).
- without the macro, offset 4 reads 0.
